// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// buffers responses in a small FIFO and hands {instruction, pc} to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] INSTR_PC,
  input  logic        INSTR_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic        run;
  logic [31:0] pc;
  cnt_t        outstanding;
  cnt_t        discard;
  cnt_t        fifo_count;

  logic [31:0] ifq_pc [DEPTH];
  ptr_t        ifq_wr;
  ptr_t        ifq_rd;

  logic [31:0] fifo_data [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  ptr_t        fifo_wr;
  ptr_t        fifo_rd;

  logic [CW:0] credit_used;
  logic        grant;
  logic        rsp;
  logic        keep;
  logic        pop;

  // Handshakes: a request transfers when IMEM_REQ & IMEM_GNT on a rising edge;
  // a word to decode transfers when INSTR_VALID & INSTR_READY on a rising edge.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign IMEM_REQ    = run && !REDIRECT && (credit_used < (CW + 1)'(DEPTH));
  assign IMEM_ADDR   = pc;

  assign grant = IMEM_REQ && IMEM_GNT;
  assign rsp   = IMEM_RVALID && (outstanding != '0);
  assign keep  = rsp && (discard == '0);
  assign pop   = INSTR_VALID && INSTR_READY;

  assign INSTR_VALID = (fifo_count != '0);
  assign INSTRUCTION = fifo_data[fifo_rd];
  assign INSTR_PC    = fifo_pc[fifo_rd];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      run         <= 1'b0;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      ifq_wr      <= '0;
      ifq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ifq_pc[i]    <= '0;
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + cnt_t'(grant) - cnt_t'(rsp);
      if (grant) begin
        pc             <= pc + 32'd4;
        ifq_pc[ifq_wr] <= pc;
        ifq_wr         <= ifq_wr + ptr_t'(1);
      end
      // The in-flight PC queue keeps popping across redirects so it stays
      // aligned with the responses that are still on their way back.
      if (rsp) begin
        ifq_rd <= ifq_rd + ptr_t'(1);
      end
      if (REDIRECT) begin
        pc         <= {REDIRECT_PC[31:2], 2'b00};
        fifo_rd    <= fifo_wr;
        fifo_count <= '0;
        discard    <= outstanding - cnt_t'(rsp);
      end else begin
        if (rsp && (discard != '0)) begin
          discard <= discard - cnt_t'(1);
        end
        if (keep) begin
          fifo_data[fifo_wr] <= IMEM_RDATA;
          fifo_pc[fifo_wr]   <= ifq_pc[ifq_rd];
          fifo_wr            <= fifo_wr + ptr_t'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + ptr_t'(1);
        end
        fifo_count <= fifo_count + cnt_t'(keep) - cnt_t'(pop);
      end
    end
  end

  // A response with nothing outstanding breaks the memory protocol; it is ignored.
  always_ff @(posedge CLK) begin
    if (RESET_N) begin
      assert (!(IMEM_RVALID && (outstanding == '0)))
        else $error("instr_fetch_unit: IMEM_RVALID with no outstanding request");
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a DEPTH=2 unit with a configurable memory
// model and scoreboard, plus a DEPTH=4 unit starting near the top of memory.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        m_req, m_gnt = 1'b0, m_rvalid = 1'b0, m_valid, m_ready = 1'b0, m_redir = 1'b0;
  logic [31:0] m_addr, m_rdata = '0, m_instr, m_pc, m_rpc = '0;
  logic        b_req, b_gnt = 1'b0, b_rvalid = 1'b0, b_valid, b_ready = 1'b0, b_redirect = 1'b0;
  logic [31:0] b_addr, b_rdata = '0, b_instr, b_pc, b_rpc = '0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .CLK(clk), .RESET_N(rst_n), .IMEM_REQ(m_req), .IMEM_ADDR(m_addr), .IMEM_GNT(m_gnt),
    .IMEM_RVALID(m_rvalid), .IMEM_RDATA(m_rdata), .INSTR_VALID(m_valid), .INSTRUCTION(m_instr),
    .INSTR_PC(m_pc), .INSTR_READY(m_ready), .REDIRECT(m_redir), .REDIRECT_PC(m_rpc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) b_dut (
    .CLK(clk), .RESET_N(rst_n), .IMEM_REQ(b_req), .IMEM_ADDR(b_addr), .IMEM_GNT(b_gnt),
    .IMEM_RVALID(b_rvalid), .IMEM_RDATA(b_rdata), .INSTR_VALID(b_valid), .INSTRUCTION(b_instr),
    .INSTR_PC(b_pc), .INSTR_READY(b_ready), .REDIRECT(b_redirect), .REDIRECT_PC(b_rpc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0BAD_C0DE;
  endfunction

  // memory model and scoreboard for the DEPTH=2 unit
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] cons_log[$];
  logic [31:0] exp_addr;
  int lat, gnt_delay, wait_cnt, n_grants, n_cons, first_grant, first_valid, cyc = 0, since = 0;
  bit rand_mode;

  // fixed-latency (2) memory and logs for the DEPTH=4 unit
  logic [31:0] b_pend[$];
  int          b_due[$];
  logic [31:0] b_gnt_log[$], b_pc_log[$], b_ins_log[$], b_post_log[$];
  int          b_tick_log[$];
  bit          b_redir, b_post;

  task automatic tick(input bit redir, input logic [31:0] rpc, input bit ready);
    bit rsp, b_rsp;
    @(negedge clk);
    m_redir  = redir;
    m_rpc    = rpc;
    m_ready  = ready;
    m_gnt    = (wait_cnt >= gnt_delay);
    rsp      = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    m_rvalid = rsp;
    m_rdata  = rsp ? mem_word(pend_addr[0]) : 32'h0;
    b_redirect = b_redir;
    b_rpc      = 32'h0000_2002;
    b_gnt      = 1'b1;
    b_ready    = 1'b1;
    b_rsp      = (b_pend.size() > 0) && (b_due[0] <= cyc);
    b_rvalid   = b_rsp;
    b_rdata    = b_rsp ? mem_word(b_pend[0]) : 32'h0;
    #1;
    if (redir) check_eq("req_during_redirect", {31'b0, m_req}, 32'h0);
    if (m_req && m_gnt) begin
      check_eq("grant_addr", m_addr, exp_addr);
      pend_addr.push_back(m_addr);
      pend_due.push_back(cyc + lat);
      exp_q.push_back(exp_addr);
      exp_addr += 32'd4;
      if (n_grants == 0) first_grant = since;
      n_grants++;
      wait_cnt = 0;
      if (rand_mode) begin
        gnt_delay = $urandom_range(0, 3);
        lat       = $urandom_range(1, 4);
      end
    end else if (m_req) begin
      wait_cnt++;
    end
    if (rsp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (m_valid) begin
      if (first_valid < 0) first_valid = since;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {31'b0, m_valid}, 32'h0);
      end else begin
        check_eq("head_pc", m_pc, exp_q[0]);
        check_eq("head_instr", m_instr, mem_word(exp_q[0]));
        if (ready && !redir) begin
          void'(exp_q.pop_front());
          cons_log.push_back(m_pc);
          n_cons++;
        end
      end
    end
    if (redir) begin
      exp_q.delete();
      cons_log.delete();
      exp_addr = {rpc[31:2], 2'b00};
    end
    if (b_req) begin
      b_pend.push_back(b_addr);
      b_due.push_back(cyc + 2);
      b_gnt_log.push_back(b_addr);
    end
    if (b_rsp) begin
      void'(b_pend.pop_front());
      void'(b_due.pop_front());
    end
    if (b_valid && !b_redir) begin
      if (b_post) b_post_log.push_back(b_pc);
      else begin
        b_pc_log.push_back(b_pc);
        b_ins_log.push_back(b_instr);
        b_tick_log.push_back(since);
      end
    end
    if (b_redir) b_post = 1'b1;
    cyc++;
    since++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_ready = 1'b0; m_redir = 1'b0; m_rpc = '0;
    b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_ready = 1'b0; b_redirect = 1'b0; b_rpc = '0;
    #1;
    check_eq("rst_req", {31'b0, m_req}, 32'h0);
    check_eq("rst_valid", {31'b0, m_valid}, 32'h0);
    check_eq("rst_instr", m_instr, 32'h0);
    check_eq("rst_pc", m_pc, 32'h0);
    check_eq("rst_addr", m_addr, 32'h0);
    check_eq("b_rst_addr", b_addr, 32'hFFFF_FFF8);
    check_eq("b_rst_valid", {31'b0, b_valid}, 32'h0);
    pend_addr.delete(); pend_due.delete(); exp_q.delete(); cons_log.delete();
    b_pend.delete(); b_due.delete(); b_gnt_log.delete(); b_pc_log.delete();
    b_ins_log.delete(); b_post_log.delete(); b_tick_log.delete();
    exp_addr = 32'h0; lat = 1; gnt_delay = 0; wait_cnt = 0; rand_mode = 1'b0;
    n_grants = 0; n_cons = 0; first_grant = -1; first_valid = -1;
    b_redir = 1'b0; b_post = 1'b0; since = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("req_first_cycle", {31'b0, m_req}, 32'h0);
    check_eq("b_req_first_cycle", {31'b0, b_req}, 32'h0);
  endtask

  initial begin
    // free run with 1-cycle memory; DEPTH=4 unit wraps and takes a redirect with a pop
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      b_redir = (k == 7);
      tick(1'b0, 32'h0, 1'b1);
      if (k == 8) begin
        check_eq("b_valid_after_redirect", {31'b0, b_valid}, 32'h0);
        check_eq("b_discard", 32'(b_dut.discard), 32'd1);
      end
    end
    b_redir = 1'b0;
    check_eq("valid_latency", 32'(first_valid - first_grant), 32'd2);
    check_eq("seq_pc0", cons_log[0], 32'h0);
    check_eq("seq_pc1", cons_log[1], 32'h4);
    check_eq("seq_pc2", cons_log[2], 32'h8);
    check_eq("seq_pc3", cons_log[3], 32'hC);
    check_eq("b_gnt0", b_gnt_log[0], 32'hFFFF_FFF8);
    check_eq("b_gnt1", b_gnt_log[1], 32'hFFFF_FFFC);
    check_eq("b_gnt2", b_gnt_log[2], 32'h0000_0000);
    check_eq("b_cons_count", 32'(b_pc_log.size()), 32'd3);
    check_eq("b_pc0", b_pc_log[0], 32'hFFFF_FFF8);
    check_eq("b_pc1", b_pc_log[1], 32'hFFFF_FFFC);
    check_eq("b_pc2", b_pc_log[2], 32'h0000_0000);
    check_eq("b_ins0", b_ins_log[0], mem_word(32'hFFFF_FFF8));
    check_eq("b_ins2", b_ins_log[2], mem_word(32'h0000_0000));
    check_eq("b_no_bubble1", 32'(b_tick_log[1] - b_tick_log[0]), 32'd1);
    check_eq("b_no_bubble2", 32'(b_tick_log[2] - b_tick_log[1]), 32'd1);
    check_eq("b_post_redirect_pc", b_post_log[0], 32'h0000_2000);

    // decode stalled: credit stops fetch after two grants
    do_reset();
    for (int k = 0; k < 10; k++) tick(1'b0, 32'h0, 1'b0);
    check_eq("stall_grants", 32'(n_grants), 32'd2);
    check_eq("stall_req_low", {31'b0, m_req}, 32'h0);
    for (int k = 0; k < 8; k++) tick(1'b0, 32'h0, 1'b1);
    check_eq("stall_out0", cons_log[0], 32'h0);
    check_eq("stall_out1", cons_log[1], 32'h4);
    check_eq("stall_resume", 32'(n_grants >= 3), 32'd1);

    // redirect with two responses in flight
    do_reset();
    lat = 3;
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    check_eq("inflight_two", 32'(pend_addr.size()), 32'd2);
    tick(1'b1, 32'h0000_0103, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    check_eq("addr_after_redirect", m_addr, 32'h0000_0100);
    check_eq("discard_two", 32'(dut.discard), 32'd2);
    for (int k = 0; k < 14; k++) tick(1'b0, 32'h0, 1'b1);
    check_eq("post_redirect_pc", cons_log[0], 32'h0000_0100);

    // delayed grants, variable latency, toggling ready, occasional redirects
    do_reset();
    rand_mode = 1'b1;
    gnt_delay = 3;
    lat = 4;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) tick(1'b1, $urandom, 1'($urandom_range(0, 1)));
      else tick(1'b0, 32'h0, 1'($urandom_range(0, 1)));
    end
    check_eq("rand_progress", 32'(n_cons >= 40), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate extender and main decoder in the RISC-V core.
- Owns the PC and issues in-order word requests to instruction memory over a request/grant plus response-valid handshake.
- Buffers returned words in a 2-entry FIFO and presents INSTRUCTION, with its PC, to decode under valid/ready.
- Accepts redirects from branch/jump resolution; wrong-path responses still in flight are dropped.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, instruction buffer entries and maximum in-flight credit; legal values 2 or 4

Ports:
CLK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
IMEM_REQ  output  1  fetch request valid
IMEM_ADDR  output  32  word-aligned fetch address; always equals PC
IMEM_GNT  input  1  request accepted this cycle when IMEM_REQ=1
IMEM_RVALID  input  1  response valid; one response per grant, in order, at least 1 cycle after its grant
IMEM_RDATA  input  32  response instruction word
INSTR_VALID  output  1  FIFO head valid
INSTRUCTION  output  32  FIFO head instruction, to decoder and extender
INSTR_PC  output  32  address of the FIFO head instruction
INSTR_READY  input  1  decode consumes the head this cycle
REDIRECT  input  1  branch/jump taken; one-cycle pulse
REDIRECT_PC  input  32  new fetch target

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - PC=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - IMEM_REQ=0, INSTR_VALID=0, INSTRUCTION=0, INSTR_PC=0.
  - A reset during in-flight requests drops them. Memory is reset alongside, so no responses arrive afterwards.
- Credit: IMEM_REQ=1 when REDIRECT=0 and (outstanding + fifo_count) < DEPTH. Combinational; IMEM_REQ is 0 in the first cycle after reset release because of a registered run flag.
- Grant (IMEM_REQ & IMEM_GNT):
  - PC <= PC+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
  - outstanding increments.
  - The request PC is pushed into a DEPTH-entry in-flight PC queue.
- Response (IMEM_RVALID):
  - outstanding decrements and the in-flight PC queue pops.
  - If discard>0: discard decrements and the data is dropped.
  - Otherwise {IMEM_RDATA, popped PC} is written to the FIFO tail.
  - Credit accounting guarantees the FIFO is never full on a write. A response with outstanding=0 is a protocol error: ignore it and flag it in simulation with $error.
- Consume: INSTR_VALID & INSTR_READY pops the head.
  - The head is visible the cycle after its response arrives; there is no response-to-output bypass.
  - Fetch-to-decode latency with a 1-cycle memory is 2 cycles after grant.
- Simultaneous events:
  - Push and pop in the same cycle keep fifo_count unchanged, and the data order is preserved.
  - Grant and response in the same cycle keep outstanding unchanged.
- Redirect (REDIRECT=1), with priority over everything else:
  - PC <= {REDIRECT_PC[31:2], 2'b00}.
  - FIFO flushed; INSTR_VALID=0 next cycle. A same-cycle pop has no further effect.
  - discard <= outstanding minus a same-cycle response, plus 0 because no grant is possible this cycle.
  - The in-flight PC queue is retained for alignment only.
  - A same-cycle response is dropped regardless.
- Back-to-back redirects: the last one wins. discard is recomputed each time from live outstanding.
- Stall: with INSTR_READY=0 held, fetch stops once fifo_count + outstanding = DEPTH. No words are lost or duplicated.
- Outputs are registered from FIFO storage. INSTRUCTION and INSTR_PC hold their value while INSTR_VALID=1 and READY=0.

Test Plan:
- Reset release, 1-cycle memory with GNT=1, READY=1 -> IMEM_ADDR sequence 0,4,8,C. INSTR_VALID rises 2 cycles after the first grant. INSTRUCTION/INSTR_PC pairs match memory contents at 0,4,8,C in order, with no bubbles at steady state.
- READY=0 for 10 cycles with DEPTH=2 -> exactly 2 grants (addresses 0,4), then IMEM_REQ=0. On READY=1 the output is 0 then 4, then fetch resumes at 8.
- Redirect to 32'h0000_0103 with 2 responses in flight -> next IMEM_ADDR=32'h100. Both stale responses are dropped. The first INSTR_PC after the redirect is 32'h100.
- Redirect coincident with a response and an INSTR_READY pop -> the response is dropped, the FIFO is empty next cycle, and discard equals the remaining outstanding count (1).
- RESET_PC=32'hFFFF_FFF8, free-run -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; INSTR_PC wraps identically.
- Grant delayed 3 cycles and response latency 4 cycles, randomized with READY toggling -> scoreboard shows every word delivered exactly once, in order, with the correct PC.
